// File: rtl/dct_group_scheduler.sv
// dct_group_scheduler
//   Sequences the DCT engine array against the ingester's double-buffered MCU RAM.
//   Each ingester buffer swap starts a run of GROUPS MCU groups. Before each group
//   the DCT engines are held in reset for RESET_HOLD cycles. The DCT output pointer
//   rotates through NUM_OUTBUFS output buffers. Occupancy of those buffers is tracked
//   against a downstream release strobe, and the DCTs stall while every buffer is full.
//
//   Optional feature macro: DCT_SCHED_OVERRUN_RECOVER_EN
//     defined   : an ingester swap during a run restarts the run (HOLD, groups cleared)
//     undefined : an ingester swap during a run locks the block in ERROR until reset
//
// Ports
//   clock                       in   system clock, all state on posedge
//   reset                       in   synchronous, active-high
//   ingester_frontbuffer_select in   ingester buffer select; any toggle = new buffer ready
//   dcts_finished               in   DCT engines done with the current group (ACTIVE only)
//   outbuf_release              in   strobe: downstream drained the oldest output buffer
//   dct_nreset                  out  DCT engine reset, low = held
//   dcts_frontbuffer            out  output buffer index the DCTs write
//   mcu_groups_processed        out  groups completed in the current ingester buffer
//   outbuf_count                out  output buffers filled and not yet released
//   outbufs_full                out  outbuf_count == NUM_OUTBUFS
//   overrun                     out  sticky: ingester swapped mid-run
//   busy                        out  state is not IDLE

module dct_group_scheduler #(
    parameter int unsigned GROUPS      = 8,
    parameter int unsigned NUM_OUTBUFS = 4,
    parameter int unsigned RESET_HOLD  = 3,
    localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int unsigned OW = (NUM_OUTBUFS > 1) ? $clog2(NUM_OUTBUFS) : 1,
    localparam int unsigned CW = $clog2(NUM_OUTBUFS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ingester_frontbuffer_select,
    input  logic          dcts_finished,
    input  logic          outbuf_release,
    output logic          dct_nreset,
    output logic [OW-1:0] dcts_frontbuffer,
    output logic [GW-1:0] mcu_groups_processed,
    output logic [CW-1:0] outbuf_count,
    output logic          outbufs_full,
    output logic          overrun,
    output logic          busy
);

    localparam int unsigned HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [HW-1:0] HoldLast  = HW'(RESET_HOLD - 1);
    localparam logic [GW-1:0] GroupLast = GW'(GROUPS - 1);
    localparam logic [OW-1:0] FbLast    = OW'(NUM_OUTBUFS - 1);
    localparam logic [CW-1:0] CountFull = CW'(NUM_OUTBUFS);

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StStall,
        StActive,
        StError
    } state_e;

    state_e        state;
    logic          sel_q0;
    logic          sel_q1;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] groups;
    logic          swapped;
    logic          in_run;
    logic          complete;
    logic          release_ok;

    assign swapped    = sel_q0 ^ sel_q1;
    assign in_run     = (state == StHold) || (state == StStall) || (state == StActive);
    // A swap in ACTIVE wins over a same-cycle finish, so that group is not counted.
    assign complete   = (state == StActive) && dcts_finished && !swapped;
    // Releasing an empty set of buffers is meaningless and ignored.
    assign release_ok = outbuf_release && (outbuf_count != '0);

    assign outbufs_full         = (outbuf_count == CountFull);
    assign dct_nreset           = (state == StActive);
    assign busy                 = (state != StIdle);
    assign mcu_groups_processed = groups;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= StIdle;
            sel_q0           <= 1'b0;
            sel_q1           <= 1'b0;
            hold_cnt         <= '0;
            groups           <= '0;
            dcts_frontbuffer <= '0;
            outbuf_count     <= '0;
            overrun          <= 1'b0;
        end else begin
            sel_q0 <= ingester_frontbuffer_select;
            sel_q1 <= sel_q0;

            // Occupancy is frozen in ERROR along with every other counter.
            if (state != StError) begin
                if (complete && !release_ok) begin
                    outbuf_count <= outbuf_count + CW'(1);
                end else if (!complete && release_ok) begin
                    outbuf_count <= outbuf_count - CW'(1);
                end
            end

            if (swapped && in_run) begin
                overrun <= 1'b1;
`ifdef DCT_SCHED_OVERRUN_RECOVER_EN
                // Partial group dropped: pointer and occupancy left untouched.
                state    <= StHold;
                groups   <= '0;
                hold_cnt <= '0;
`else
                state    <= StError;
`endif
            end else begin
                case (state)
                    StIdle: begin
                        groups   <= '0;
                        hold_cnt <= '0;
                        if (swapped) begin
                            state <= StHold;
                        end
                    end
                    StHold: begin
                        if (hold_cnt == HoldLast) begin
                            hold_cnt <= '0;
                            state    <= outbufs_full ? StStall : StActive;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    StStall: begin
                        if (!outbufs_full) begin
                            state <= StActive;
                        end
                    end
                    StActive: begin
                        if (dcts_finished) begin
                            dcts_frontbuffer <= (dcts_frontbuffer == FbLast) ? '0
                                              : dcts_frontbuffer + OW'(1);
                            if (groups == GroupLast) begin
                                groups <= '0;
                                state  <= StIdle;
                            end else begin
                                groups <= groups + GW'(1);
                                state  <= StHold;
                            end
                        end
                    end
                    StError: begin
                        state <= StError;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
